// File: rtl/fft_mem_w_ctrl.sv
// Write-side address/enable generator for the 16-point FFT working memory: bank 0 load, banks 1..NSTG butterfly write-back.
// Optional macro WR_BITREV_LOAD_EN selects bit-reversed sample ordering in bank 0.
module fft_mem_w_ctrl #(
    parameter int NPT  = 16,
    parameter int NSTG = 3,
    parameter int AW   = 7
) (
    input  logic          iCLK,
    input  logic          iRSTn,
    input  logic          iCLR,
    input  logic          iLOAD,
    input  logic          iIN_VALID,
    input  logic          iBF_VALID,
    output logic          oWE,
    output logic [AW-1:0] WADDR,
    output logic          oStart_INT,
    output logic          oDONE,
    output logic          oBUSY,
    output logic          oERR,
    output logic [2:0]    STATE
);
    localparam int CW = $clog2(NPT);

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        LOAD = 3'b001,
        W1   = 3'b010,
        W2   = 3'b011,
        W3   = 3'b100
    } state_t;

    state_t        stateReg, stateNext;
    logic [CW-1:0] cntReg, cntNext;
    logic          weReg, weNext;
    logic [AW-1:0] waddrReg, waddrNext;
    logic          startReg, startNext;
    logic          doneReg, doneNext;
    logic          errReg, errNext;

    logic          beat;
    logic          lastBeat;
    logic          lastStage;
    logic [2:0]    bank;
    logic [CW-1:0] idx;
    logic [CW-1:0] loadIdx;

`ifdef WR_BITREV_LOAD_EN
    generate
        for (genvar gi = 0; gi < CW; gi++) begin : gLoadRev
            assign loadIdx[gi] = cntReg[CW-1-gi];
        end
    endgenerate
`else
    assign loadIdx = cntReg;
`endif

    always_comb begin
        beat      = 1'b0;
        bank      = 3'b000;
        idx       = cntReg;
        stateNext = stateReg;
        case (stateReg)
            LOAD: begin
                beat = iIN_VALID;
                bank = 3'b000;
                idx  = loadIdx;
            end
            W1: begin
                beat = iBF_VALID;
                bank = 3'b001;
                idx  = {cntReg[0], cntReg[3], cntReg[2], cntReg[1]};
            end
            W2: begin
                beat = iBF_VALID;
                bank = 3'b010;
                idx  = {cntReg[3], cntReg[0], cntReg[2], cntReg[1]};
            end
            W3: begin
                beat = iBF_VALID;
                bank = 3'b011;
                idx  = {cntReg[2], cntReg[1], cntReg[0], cntReg[3]};
            end
            default: begin
                beat = 1'b0;
            end
        endcase

        lastBeat  = beat && (cntReg == {CW{1'b1}});
        lastStage = (stateReg != LOAD) && (bank == 3'(NSTG));

        // iLOAD outside IDLE never restarts the frame; it only raises the error flag.
        if (stateReg == IDLE) begin
            if (iLOAD)
                stateNext = LOAD;
        end else if (lastBeat) begin
            stateNext = lastStage ? IDLE : state_t'(stateReg + 3'd1);
        end

        cntNext   = beat ? cntReg + 1'b1 : cntReg;
        weNext    = beat;
        waddrNext = beat ? {bank, idx} : waddrReg;
        startNext = lastBeat && (stateReg == LOAD);
        doneNext  = lastBeat && lastStage;
        errNext   = errReg
                  | ((stateReg == IDLE) && (iIN_VALID || iBF_VALID))
                  | ((stateReg != IDLE) && iLOAD);
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            stateReg <= IDLE;
            cntReg   <= '0;
            weReg    <= 1'b0;
            waddrReg <= '0;
            startReg <= 1'b0;
            doneReg  <= 1'b0;
            errReg   <= 1'b0;
        end else if (iCLR) begin
            stateReg <= IDLE;
            cntReg   <= '0;
            weReg    <= 1'b0;
            waddrReg <= '0;
            startReg <= 1'b0;
            doneReg  <= 1'b0;
            errReg   <= 1'b0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
            weReg    <= weNext;
            waddrReg <= waddrNext;
            startReg <= startNext;
            doneReg  <= doneNext;
            errReg   <= errNext;
        end
    end

    assign oWE        = weReg;
    assign WADDR      = waddrReg;
    assign oStart_INT = startReg;
    assign oDONE      = doneReg;
    assign oERR       = errReg;
    assign oBUSY      = (stateReg != IDLE);
    assign STATE      = stateReg;

endmodule
